data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024: number of words; power of two, at most 2^(ADDR_W-log2(DATA_W/8)).
REQ-004 SHALL have parameter WAIT_CYC, default 2: wait states per access; range 0..15.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset; synchronous and active-low.
REQ-007 SHALL have port req_valid, input, 1 bit: request present.
REQ-008 SHALL have port req_ready, output, 1 bit: controller accepts a request this cycle.
REQ-009 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-011 SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-012 SHALL have port req_be, input, DATA_W/8 bits: byte enables for writes.
REQ-013 SHALL have port rsp_valid, output, 1 bit: response pulse.
REQ-014 SHALL have port rsp_rdata, output, DATA_W bits: read data.
REQ-015 SHALL have port rsp_err, output, 1 bit: access faulted.

Function
REQ-016 SHALL define B = log2(DATA_W/8); word index = req_addr[B+log2(DEPTH)-1:B].
REQ-017 SHALL run the FSM states IDLE, WAIT and RESP.
REQ-018 SHALL drive req_ready = 1 only in IDLE; a handshake (req_valid & req_ready) captures addr, we, wdata and be into registers.
REQ-019 SHALL, on handshake, go to WAIT with wait counter = WAIT_CYC; when WAIT_CYC = 0, go directly to RESP on the next edge.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-021 SHALL perform the memory access on the edge that enters RESP.
REQ-022 SHALL make the latency from handshake edge to rsp_valid high exactly WAIT_CYC+1 cycles.
REQ-023 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-024 SHALL, on a read, set rsp_rdata = mem[index] (whole word; be ignored).
REQ-025 SHALL, on a write, update only the bytes whose be bit is 1; rsp_rdata = 0 on write responses.
REQ-026 SHALL flag a misaligned access, req_addr[B-1:0] != 0, with rsp_err = 1.
REQ-027 SHALL flag an out-of-range access, any req_addr bit above index MSB nonzero, with rsp_err = 1.
REQ-028 SHALL, on any faulting access, leave memory unmodified and set rsp_rdata = 0.
REQ-029 SHALL hold rsp_rdata and rsp_err stable from RESP until the next response.
REQ-030 SHALL treat a write with be = 0 as a legal no-op with rsp_err = 0.
REQ-031 SHALL make a read that follows a write to the same word return the written data; no hazard is possible because only one access is outstanding.
REQ-032 SHALL ignore request inputs while req_ready = 0; a req_valid held from a prior cycle is accepted only in IDLE.
REQ-033 SHALL initialise memory word i to value i (truncated to DATA_W) at time zero, for simulation only.

Reset
REQ-034 SHALL, with rst_n = 0 at a clock edge, set state = IDLE, counter = 0, rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0.
REQ-035 SHALL drive req_ready = 1 in the first cycle after rst_n returns to 1.
REQ-036 SHALL, on reset mid-access (WAIT or RESP), abort the access, produce no rsp_valid, and issue no write if memory was not yet written.
REQ-037 SHALL not alter memory contents on reset.

Verification
REQ-038 SHALL pass: reset, then read addr 0x10 with DATA_W = 32 and WAIT_CYC = 2 -> rsp_valid 3 cycles after handshake, rdata = 4, err = 0.
REQ-039 SHALL pass: write addr 0x8, wdata 0xAABBCCDD, be = 0101, then read 0x8 -> rdata = 0x00BB00DD; the original word 2 upper bytes are 0.
REQ-040 SHALL pass: read 0x6 -> err = 1, rdata = 0; read 0x1000 with DEPTH = 1024 -> err = 1.
REQ-041 SHALL pass: req_valid held high continuously -> req_ready low during WAIT and RESP, one response per access, back-to-back period WAIT_CYC+2 cycles.
REQ-042 SHALL pass: rst_n low during WAIT of a write to 0x20 -> no rsp_valid; a later read of 0x20 returns 8.
REQ-043 SHALL pass: WAIT_CYC = 0 -> read rsp_valid on the cycle after the handshake.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-port data memory controller with fixed wait states, byte enables and fault detection
module data_mem_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int NB = DATA_W / 8;
    localparam int B  = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = DATA_W'(i);
        end
        return m;
    endfunction

    // Simulation start-up contents: word i holds i.
    mem_t mem_q = mem_init();

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       be_q;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                capture;
    logic                access;
    logic                mem_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_we;
    logic [DATA_W-1:0]   acc_wdata;
    logic [NB-1:0]       acc_be;
    logic [IW-1:0]       acc_idx;
    logic                acc_fault;

    // With no wait states the access happens on the handshake edge itself,
    // so the live request is used instead of the not-yet-captured copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr  = req_addr;
            acc_we    = req_we;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_addr  = addr_q;
            acc_we    = we_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_idx   = acc_addr[B+IW-1:B];
        acc_fault = (acc_addr[B-1:0] != '0) || ((acc_addr >> (B + IW)) != '0);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        capture     = 1'b0;
        access      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_d = S_RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(WAIT_CYC);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        mem_we = access && acc_we && !acc_fault;
        if (access) begin
            rsp_err_d   = acc_fault;
            rsp_rdata_d = (acc_fault || acc_we) ? '0 : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (capture) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // Memory is never cleared by reset; a reset simply suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl with a word-array reference model
module tb_data_mem_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_valid, z_ready, z_we;
    logic [31:0] z_addr, z_wdata;
    logic [3:0]  z_be;
    logic        z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYC(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYC(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_be(z_be),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          hs;
        bit          b2b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [1024];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          last_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a plain word array; faults are misalignment or any address at or past 4 KiB.
    function automatic exp_t predict(input bit we, input logic [31:0] addr,
                                     input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        int   idx;
        e.err   = (addr % 4 != 0) || (addr >= 32'd4096);
        e.rdata = 32'h0;
        e.hs    = 0;
        e.b2b   = 1'b0;
        if (!e.err) begin
            idx = int'(addr / 4);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                e.rdata = model[idx];
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("err", 64'(rsp_err), 64'(e.err));
                check("latency", 64'(cyc - e.hs), 64'(W + 1));
                check("ready_low_in_resp", 64'(req_ready), 64'd0);
                if (e.b2b) check("b2b_period", 64'(cyc - last_rsp), 64'(W + 2));
            end
            last_rsp = cyc;
        end
    end

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be);
        exp_t e;
        bit   held;
        int   n;
        held      = req_valid;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("handshake_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        e     = predict(we, addr, wd, be);
        e.hs  = cyc;
        e.b2b = held;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic z_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        z_we = we; z_addr = addr; z_wdata = wd; z_be = be; z_valid = 1'b1;
        check("z_ready_idle", 64'(z_ready), 64'd1);
        @(negedge clk);
        z_valid = 1'b0;
        check("z_rsp_next_cycle", 64'(z_rsp_valid), 64'd1);
        check("z_rdata", 64'(z_rsp_rdata), 64'(exp_rd));
        check("z_err", 64'(z_rsp_err), 64'(exp_err));
        @(negedge clk);
        check("z_single_pulse", 64'(z_rsp_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) model[i] = 32'(i);
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        z_valid = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_err", 64'(rsp_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'd1);

        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        do_req(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101);
        do_req(1'b0, 32'h8, 32'h0, 4'h0);
        do_req(1'b0, 32'h6, 32'h0, 4'h0);
        do_req(1'b0, 32'h1000, 32'h0, 4'h0);
        do_req(1'b1, 32'hC, 32'h55667788, 4'b0000);
        do_req(1'b0, 32'hC, 32'h0, 4'h0);
        do_req(1'b1, 32'hD, 32'h99999999, 4'b1111);
        do_req(1'b1, 32'h2000_000C, 32'h99999999, 4'b1111);
        do_req(1'b0, 32'hC, 32'h0, 4'h0);
        idle(3);

        // Abort a write to 0x20 while it is waiting; memory must keep its original value.
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        check("abort_idle_ready", 64'(req_ready), 64'd1);
        do_req(1'b0, 32'h20, 32'h0, 4'h0);
        idle(2);

        for (int i = 0; i < 160; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            a = (r < 7) ? 32'($urandom_range(0, 15)) * 4 : 32'($urandom_range(0, 1023)) * 4;
            if (r == 8) a = a | 32'($urandom_range(1, 3));
            if (r == 9) a = a | (32'($urandom_range(1, 32'hFFFFF)) << 12);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
        end
        idle(W + 6);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        z_access(1'b0, 32'h10, 32'h0, 4'h0, 32'h4, 1'b0);
        z_access(1'b1, 32'h14, 32'hCAFE_F00D, 4'b1100, 32'h0, 1'b0);
        z_access(1'b0, 32'h14, 32'h0, 4'h0, 32'hCAFE_0005, 1'b0);
        z_access(1'b0, 32'h6, 32'h0, 4'h0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
